acc_buffer: RTL and testbench

Parametrised, multi-lane accumulator buffer that collects systolic-array partial sums. Each write either overwrites a row or saturating-adds into it. Each read requantises a row to the output width through an arithmetic right shift, optional ReLU and clamping. The block sits between the array output and the unified buffer write-back path, and adds a reset/clear sweep FSM plus a 2-stage registered read pipeline with a valid flag.

---
 rtl/acc_buffer_if.sv | 33 +++
 rtl/acc_buffer.sv | 165 ++++++++++++++++
 tb/tb_acc_buffer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/acc_buffer_if.sv
// Request/response bundle for acc_buffer: write port, read port, clear control and status.
interface acc_buffer_if #(
  parameter int DATA_NUM  = 16,
  parameter int DATA_SIZE = 20,
  parameter int OUT_SIZE  = 8,
  parameter int DEPTH     = 16
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(DATA_SIZE);

  logic                          clr;
  logic                          busy;
  logic                          wr_en;
  logic                          acc_en;
  logic [AW-1:0]                 wr_addr;
  logic [DATA_NUM*DATA_SIZE-1:0] wr_data;
  logic                          rd_en;
  logic [AW-1:0]                 rd_addr;
  logic [SW-1:0]                 shift;
  logic                          relu_en;
  logic                          rd_valid;
  logic [DATA_NUM*OUT_SIZE-1:0]  rd_data;

  modport master (
    output clr, wr_en, acc_en, wr_addr, wr_data, rd_en, rd_addr, shift, relu_en,
    input  busy, rd_valid, rd_data
  );

  modport slave (
    input  clr, wr_en, acc_en, wr_addr, wr_data, rd_en, rd_addr, shift, relu_en,
    output busy, rd_valid, rd_data
  );
endinterface

// File: rtl/acc_buffer.sv
// Multi-lane saturating accumulator buffer with clear sweep and 2-stage requantising read.
// Optional ACC_BUF_ROUND_EN: round half-up before the requantisation shift.
module acc_buffer #(
  parameter int DATA_NUM  = 16,
  parameter int DATA_SIZE = 20,
  parameter int OUT_SIZE  = 8,
  parameter int DEPTH     = 16
) (
  input  logic        clk,
  input  logic        rst,
  acc_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(DATA_SIZE);
  localparam int XW = DATA_SIZE + 1;
  localparam int RW = DATA_NUM * DATA_SIZE;
  localparam int QW = DATA_NUM * OUT_SIZE;

  localparam logic signed [XW-1:0] ACC_MAX = XW'((1 << (DATA_SIZE - 1)) - 1);
  localparam logic signed [XW-1:0] ACC_MIN = ~ACC_MAX;
  localparam logic signed [XW-1:0] OUT_MAX = XW'((1 << (OUT_SIZE - 1)) - 1);
  localparam logic signed [XW-1:0] OUT_MIN = ~OUT_MAX;
  localparam logic [SW-1:0]        SHIFT_MAX = SW'(DATA_SIZE - 1);

  function automatic logic signed [DATA_SIZE-1:0] sat_add(
    input logic signed [DATA_SIZE-1:0] a,
    input logic signed [DATA_SIZE-1:0] b
  );
    logic signed [XW-1:0] s;
    s = {a[DATA_SIZE-1], a} + {b[DATA_SIZE-1], b};
    if (s > ACC_MAX) return ACC_MAX[DATA_SIZE-1:0];
    if (s < ACC_MIN) return ACC_MIN[DATA_SIZE-1:0];
    return s[DATA_SIZE-1:0];
  endfunction

  function automatic logic signed [OUT_SIZE-1:0] requant(
    input logic signed [DATA_SIZE-1:0] v,
    input logic [SW-1:0]               sh,
    input logic                        relu
  );
    logic [SW-1:0]        amt;
    logic signed [XW-1:0] r;
    amt = (sh > SHIFT_MAX) ? SHIFT_MAX : sh;
    r   = {v[DATA_SIZE-1], v};
`ifdef ACC_BUF_ROUND_EN
    // One extra bit of headroom keeps the rounding bias from overflowing.
    if (amt != '0) r = r + $signed(XW'(1) << (amt - SW'(1)));
`endif
    r = r >>> amt;
    if (relu && r < 0) r = '0;
    if (r > OUT_MAX) return OUT_MAX[OUT_SIZE-1:0];
    if (r < OUT_MIN) return OUT_MIN[OUT_SIZE-1:0];
    return r[OUT_SIZE-1:0];
  endfunction

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          busy;
  logic          rd_go;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        if (bus.clr) begin
          cnt_nxt = '0;
        end else if (cnt == AW'(DEPTH - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + AW'(1);
        end
      end
      IDLE: begin
        if (bus.clr) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: ;
    endcase
  end

  assign busy     = (state == CLEAR);
  assign bus.busy = busy;
  assign rd_go    = bus.rd_en && !busy;

  logic [RW-1:0] mem [DEPTH];
  logic [RW-1:0] cur_row;
  logic [RW-1:0] wr_row;

  always_comb begin
    wr_row  = '0;
    cur_row = mem[bus.wr_addr];
    for (int i = 0; i < DATA_NUM; i++) begin
      wr_row[i*DATA_SIZE +: DATA_SIZE] = bus.acc_en
        ? sat_add($signed(cur_row[i*DATA_SIZE +: DATA_SIZE]), $signed(bus.wr_data[i*DATA_SIZE +: DATA_SIZE]))
        : bus.wr_data[i*DATA_SIZE +: DATA_SIZE];
    end
  end

  // The sweep owns the write port while busy; the read-modify-write closes in one edge.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt] <= '0;
    end else if (bus.wr_en) begin
      mem[bus.wr_addr] <= wr_row;
    end
  end

  // ---- stage 1: row fetch (sees pre-write contents on a same-row write) ----
  logic [RW-1:0] row_p1;
  logic [SW-1:0] shift_p1;
  logic          relu_p1;
  logic          vld_p1;

  always_ff @(posedge clk) begin
    if (rd_go) begin
      row_p1   <= mem[bus.rd_addr];
      shift_p1 <= bus.shift;
      relu_p1  <= bus.relu_en;
    end
  end

  logic [QW-1:0] q_p1;

  always_comb begin
    q_p1 = '0;
    for (int i = 0; i < DATA_NUM; i++) begin
      q_p1[i*OUT_SIZE +: OUT_SIZE] = requant($signed(row_p1[i*DATA_SIZE +: DATA_SIZE]), shift_p1, relu_p1);
    end
  end

  // ---- stage 2: requantised output register, held between valid pulses ----
  logic [QW-1:0] data_p2;
  logic          vld_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      data_p2 <= '0;
    end else begin
      vld_p1 <= rd_go;
      vld_p2 <= vld_p1;
      if (vld_p1) data_p2 <= q_p1;
    end
  end

  assign bus.rd_valid = vld_p2;
  assign bus.rd_data  = data_p2;
endmodule

// File: tb/tb_acc_buffer.sv
// Directed bench for acc_buffer: clear sweep, overwrite/accumulate, saturation, requantisation, hazards.
module tb_acc_buffer;
  localparam int DN = 16;
  localparam int DS = 20;
  localparam int OS = 8;
  localparam int DP = 16;
  localparam int AW = $clog2(DP);
  localparam int SW = $clog2(DS);

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n;
  int   vcnt;
  logic [DN*DS-1:0] row_v;

  acc_buffer_if #(.DATA_NUM(DN), .DATA_SIZE(DS), .OUT_SIZE(OS), .DEPTH(DP)) bus ();

  acc_buffer #(.DATA_NUM(DN), .DATA_SIZE(DS), .OUT_SIZE(OS), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [31:0] lane(input int i);
    logic signed [OS-1:0] v;
    v = bus.rd_data[i*OS +: OS];
    return 32'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clr = 0; bus.wr_en = 0; bus.acc_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_en = 0; bus.rd_addr = '0; bus.shift = '0; bus.relu_en = 0;
  endtask

  task automatic wr(input int addr, input int v0, input bit acc);
    bus.wr_en = 1; bus.acc_en = acc; bus.wr_addr = AW'(addr);
    bus.wr_data = '0;
    bus.wr_data[DS-1:0] = DS'(v0);
    tick();
    bus.wr_en = 0; bus.acc_en = 0;
  endtask

  task automatic rd(input string tag, input int addr, input int sh, input bit relu);
    bus.rd_en = 1; bus.rd_addr = AW'(addr); bus.shift = SW'(sh); bus.relu_en = relu;
    tick();
    bus.rd_en = 0;
    check_eq({tag, "_vld_early"}, 32'(bus.rd_valid), 0);
    tick();
    check_eq({tag, "_vld"}, 32'(bus.rd_valid), 1);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    tick(); tick();
    check_eq("rst_busy", 32'(bus.busy), 1);
    check_eq("rst_rd_valid", 32'(bus.rd_valid), 0);
    check_eq("rst_rd_data", 32'(bus.rd_data != '0), 0);
    rst = 0;
    n = 0;
    while (bus.busy && n < 40) begin tick(); n++; end
    check_eq("sweep_len", n, 16);

    rd("init_r5", 5, 0, 0);
    check_eq("init_r5_l0", lane(0), 0);
    check_eq("init_r5_l15", lane(15), 0);

    wr(3, 100, 0);
    wr(3, 50, 1);
    rd("acc_s0", 3, 0, 0);
    check_eq("acc_s0_l0", lane(0), 127);
    tick();
    check_eq("rd_valid_pulse", 32'(bus.rd_valid), 0);
    check_eq("rd_data_hold", lane(0), 127);
    rd("acc_s1", 3, 1, 0);
    check_eq("acc_s1_l0", lane(0), 75);

    row_v = '0;
    for (int j = 0; j < DN; j++) row_v[j*DS +: DS] = DS'(j*10 - 70);
    bus.wr_en = 1; bus.acc_en = 0; bus.wr_addr = AW'(1); bus.wr_data = row_v;
    tick();
    bus.wr_en = 0;
    rd("lanes", 1, 0, 0);
    check_eq("lanes_l0", lane(0), -70);
    check_eq("lanes_l7", lane(7), 0);
    check_eq("lanes_l15", lane(15), 80);

    wr(2, 1, 0);
    wr(2, 2, 1);
    wr(2, 4, 1);
    rd("b2b", 2, 0, 0);
    check_eq("b2b_l0", lane(0), 7);

    wr(4, 3, 0);
    rd("rnd_p", 4, 1, 0);
`ifdef ACC_BUF_ROUND_EN
    check_eq("rnd_p_l0", lane(0), 2);
`else
    check_eq("rnd_p_l0", lane(0), 1);
`endif
    wr(4, -3, 0);
    rd("rnd_n", 4, 1, 0);
`ifdef ACC_BUF_ROUND_EN
    check_eq("rnd_n_l0", lane(0), -1);
`else
    check_eq("rnd_n_l0", lane(0), -2);
`endif

    wr(6, 524287, 0);
    wr(6, 1, 1);
    rd("satp_s0", 6, 0, 0);
    check_eq("satp_s0_l0", lane(0), 127);
    rd("satp_s13", 6, 13, 0);
`ifdef ACC_BUF_ROUND_EN
    check_eq("satp_s13_l0", lane(0), 64);
`else
    check_eq("satp_s13_l0", lane(0), 63);
`endif
    wr(6, -524288, 0);
    wr(6, -5, 1);
    rd("satn_s0", 6, 0, 0);
    check_eq("satn_s0_l0", lane(0), -128);
    rd("satn_s13", 6, 13, 0);
    check_eq("satn_s13_l0", lane(0), -64);

    wr(8, -200, 0);
    rd("relu_on", 8, 0, 1);
    check_eq("relu_on_l0", lane(0), 0);
    rd("relu_off", 8, 0, 0);
    check_eq("relu_off_l0", lane(0), -128);
    rd("big_shift", 8, 31, 0);
`ifdef ACC_BUF_ROUND_EN
    check_eq("big_shift_l0", lane(0), 0);
`else
    check_eq("big_shift_l0", lane(0), -1);
`endif

    wr(7, 10, 0);
    bus.rd_en = 1; bus.rd_addr = AW'(7); bus.shift = '0; bus.relu_en = 0;
    bus.wr_en = 1; bus.acc_en = 0; bus.wr_addr = AW'(7);
    bus.wr_data = '0; bus.wr_data[DS-1:0] = DS'(20);
    tick();
    idle_inputs();
    tick();
    check_eq("rbw_vld", 32'(bus.rd_valid), 1);
    check_eq("rbw_old", lane(0), 10);
    rd("rbw_new", 7, 0, 0);
    check_eq("rbw_new_l0", lane(0), 20);

    for (int r = 0; r < DP; r++) wr(r, 9, 0);
    bus.rd_en = 1; bus.rd_addr = AW'(4); bus.shift = '0; bus.relu_en = 0;
    tick();
    bus.rd_en = 0;
    bus.clr = 1;
    tick();
    bus.clr = 0;
    check_eq("clr_inflight_vld", 32'(bus.rd_valid), 1);
    check_eq("clr_inflight_l0", lane(0), 9);
    n = 0;
    vcnt = 0;
    while (bus.busy && n < 40) begin
      bus.wr_en = 1; bus.acc_en = 0; bus.wr_addr = '0;
      bus.wr_data = '0; bus.wr_data[DS-1:0] = DS'(55);
      bus.rd_en = 1; bus.rd_addr = AW'(4);
      tick();
      n++;
      if (bus.rd_valid) vcnt++;
    end
    idle_inputs();
    tick(); if (bus.rd_valid) vcnt++;
    tick(); if (bus.rd_valid) vcnt++;
    check_eq("clr_busy_len", n, 16);
    check_eq("clr_busy_reads", vcnt, 0);
    rd("clr_r0", 0, 0, 0);
    check_eq("clr_r0_l0", lane(0), 0);
    rd("clr_r4", 4, 0, 0);
    check_eq("clr_r4_l0", lane(0), 0);
    rd("clr_r15", 15, 0, 0);
    check_eq("clr_r15_l0", lane(0), 0);

    wr(5, 40, 0);
    rd("pre_rst", 5, 0, 0);
    check_eq("pre_rst_l0", lane(0), 40);
    rst = 1;
    #1;
    check_eq("async_rst_vld", 32'(bus.rd_valid), 0);
    check_eq("async_rst_data", lane(0), 0);
    check_eq("async_rst_busy", 32'(bus.busy), 1);
    tick();
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
